// File: rtl/fetch_stage_pkg.sv
// Core-wide constants and types shared by the fetch, decode and hazard logic.
// Holds XLEN, the NOP encoding, the default reset PC and the IF/ID record layout.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc_plus4;
        logic  valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    function automatic word_t pc_align(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic if_id_t make_bubble(input word_t nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register: sync active-low reset, sync clear-to-value, enable.
// Priority is reset > clear > enable, so a flush always beats a stall.
module pipe_reg_en_clr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // NOTE: the hold value is assigned first so every path through the block drives q_d; no latch.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = CLR_VAL;
        end else if (en) begin
            q_d = d;
        end
    end

    // NOTE: non-blocking assignment for state so all flops sample their inputs from the same instant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// A redirect from execute overrides a fetch stall; a decode flush overrides a decode stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam if_id_t BUBBLE = make_bubble(NOP_INSTR);

    word_t  pc_plus4_f;
    word_t  pc_next;
    logic   pc_en;
    if_id_t if_id_d;
    if_id_t if_id_q;

    always_comb begin
        pc_plus4_f = PCF + word_t'(4);
        pc_next    = PCSrcE ? pc_align(PCTargetE) : pc_plus4_f;
        // Redirect must land even while fetch is stalled, otherwise the target is lost.
        pc_en      = !StallF || PCSrcE;

        if_id_d.instr    = InstrF;
        if_id_d.pc       = PCF;
        if_id_d.pc_plus4 = pc_plus4_f;
        if_id_d.valid    = 1'b1;
    end

    pipe_reg_en_clr #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC),
        .CLR_VAL   ('0)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .clr (1'b0),
        .d   (pc_next),
        .q   (PCF)
    );

    pipe_reg_en_clr #(
        .WIDTH     (IF_ID_W),
        .RESET_VAL (BUBBLE),
        .CLR_VAL   (BUBBLE)
    ) u_if_id_reg (
        .clk (clk),
        .rst (rst),
        .en  (!StallD),
        .clr (FlushD),
        .d   (if_id_d),
        .q   (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes model predictions, a monitor pops after each edge.
// Instruction memory is a pure function of the word address so every fetch is identifiable.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
        logic        valid;
    } exp_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];

    // Reference model state: architectural view of the fetch pipeline.
    logic [31:0] m_pc    = 32'hx;
    logic [31:0] m_instr = 32'hx;
    logic [31:0] m_pcd   = 32'hx;
    logic [31:0] m_pcp4  = 32'hx;
    logic        m_valid = 1'bx;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        return {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    assign InstrF = instr_at(PCF);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the rules of the fetch stage, queue the prediction.
    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        if (!r) begin
            m_pc = RESET_PC;
            m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
        end else begin
            logic [31:0] cur_pc;
            cur_pc = m_pc;
            if (ps)       m_pc = tgt & 32'hFFFF_FFFC;
            else if (!sf) m_pc = cur_pc + 32'd4;
            if (fd) begin
                m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
            end else if (!sd) begin
                m_instr = instr_at(cur_pc); m_pcd = cur_pc; m_pcp4 = cur_pc + 32'd4; m_valid = 1;
            end
        end
        e.pcf = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pcp4 = m_pcp4; e.valid = m_valid;
        sb_q.push_back(e);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: the stage presents a new state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("PCF",      PCF,      e.pcf);
                check("InstrD",   InstrD,   e.instr);
                check("PCD",      PCD,      e.pcd);
                check("PCPlus4D", PCPlus4D, e.pcp4);
                check("ValidD",   {31'b0, ValidD}, {31'b0, e.valid});
            end
        end
    end

    initial begin
        rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;

        // Reset with every control input active: reset must win.
        step(0, 1, 1, 1, 1, 32'h0000_0100);
        step(0, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #2;
        check("rst_PCF", PCF, RESET_PC);
        check("rst_InstrD", InstrD, NOP);
        check("rst_ValidD", {31'b0, ValidD}, 32'h0);

        // Free run reaches PCF=8, then a two-cycle load-use stall and release.
        free_run(2);
        @(posedge clk); #2;
        check("run_PCF8", PCF, 32'h8);
        check("run_PCD4", PCD, 32'h4);
        step(1, 1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0, 0, 32'h0);
        @(posedge clk); #2;
        check("stall_PCF", PCF, 32'h8);
        check("stall_InstrD", InstrD, instr_at(32'h4));
        free_run(2);
        @(posedge clk); #2;
        check("release_PCD", PCD, 32'hC);

        // Taken branch to 0x40 with flush; target reaches decode on the second edge.
        step(1, 0, 0, 1, 1, 32'h0000_0040);
        @(posedge clk); #2;
        check("br_PCF", PCF, 32'h40);
        check("br_bubble", InstrD, NOP);
        free_run(1);
        @(posedge clk); #2;
        check("br_InstrD", InstrD, instr_at(32'h40));

        // Misaligned target, redirect beating StallF, flush beating StallD.
        step(1, 1, 1, 1, 1, 32'h0000_0043);
        @(posedge clk); #2;
        check("align_PCF", PCF, 32'h40);
        check("flush_stall_valid", {31'b0, ValidD}, 32'h0);
        free_run(2);

        // PC wrap at the top of the address space.
        step(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
        free_run(1);
        @(posedge clk); #2;
        check("wrap_PCF", PCF, 32'h0);
        check("wrap_PCPlus4D", PCPlus4D, 32'h0);

        // Reset while stalled and redirecting discards the redirect.
        step(1, 1, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 1, 32'h0000_0200);
        @(posedge clk); #2;
        check("rst_mid_PCF", PCF, RESET_PC);
        check("rst_mid_InstrD", InstrD, NOP);
        free_run(1);

        // Randomized control mix.
        for (int i = 0; i < 400; i++) begin
            logic r, sf, sd, fd, ps;
            logic [31:0] t;
            r  = ($urandom_range(0, 31) != 0);
            sf = ($urandom_range(0, 3) == 0);
            sd = sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            ps = ($urandom_range(0, 7) == 0);
            fd = ps ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, sf, sd, fd, ps, t);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the PC value loaded at reset.
REQ-002 The block SHALL take parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), as the bubble inserted into the decode register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 StallF  input  1  hold PCF (load-use stall).
REQ-006 StallD  input  1  hold the IF/ID register (load-use stall).
REQ-007 FlushD  input  1  replace IF/ID contents with a bubble (taken branch/jump).
REQ-008 PCSrcE  input  1  redirect fetch to PCTargetE.
REQ-009 PCTargetE  input  32  branch/jump target computed in execute.
REQ-010 InstrF  input  32  instruction read combinationally from instruction memory at PCF.
REQ-011 PCF  output  32  current fetch address to instruction memory.
REQ-012 InstrD  output  32  decode-stage instruction.
REQ-013 PCD  output  32  PC of InstrD.
REQ-014 PCPlus4D  output  32  PCD+4.
REQ-015 ValidD  output  1  1 = InstrD is a real fetched instruction, 0 = bubble.

Function
REQ-016 PCPlus4F SHALL equal PCF+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-017 Next PC SHALL be PCTargetE with bits [1:0] forced to 2'b00 when PCSrcE=1, else PCPlus4F.
REQ-018 PCF SHALL load next PC each cycle StallF=0; hold when StallF=1 and PCSrcE=0.
REQ-019 When PCSrcE=1 and StallF=1 in the same cycle, redirect SHALL win: PCF loads the target.
REQ-020 IF/ID SHALL capture {InstrF, PCF, PCPlus4F, ValidD=1} each cycle StallD=0 and FlushD=0.
REQ-021 StallD=1 and FlushD=0 SHALL hold all IF/ID outputs unchanged.
REQ-022 FlushD=1 SHALL load InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0 regardless of StallD (flush beats stall).
REQ-023 Latency: instruction at PCF in cycle n SHALL appear on InstrD in cycle n+1 absent stall/flush.
REQ-024 A stall SHALL lose no instruction: after StallF=StallD=1 for k cycles, the held instruction and the next sequential one SHALL issue in order with no duplicate or gap.
REQ-025 Taken-branch penalty: the instruction fetched in the redirect cycle SHALL be discarded via FlushD; the target instruction SHALL reach InstrD on the second edge after PCSrcE.
REQ-026 The block SHALL hold no other state; PCF is the only combinational-path output to memory (no InstrF->PCF loop).

Reset
REQ-027 With rst=0 at a rising edge: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-028 Reset SHALL override StallF, StallD, FlushD and PCSrcE in the same cycle.
REQ-029 First edge with rst=1 SHALL capture the instruction at RESET_PC into IF/ID and advance PCF to RESET_PC+4.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation entirely.

Structure
REQ-031 XLEN=32, the NOP encoding, and the reset PC default SHALL live in the shared core package, used also by the decode stage and hazard logic.
REQ-032 One sub-module, pipe_reg_en_clr (parameterised width; enable, synchronous clear-to-value, active-low sync reset), SHALL implement both the PC register and IF/ID; reusable for later stage registers.

Verification
REQ-033 Reset then free-run 4 cycles, InstrF=mem[PCF/4] -> PCF 0,4,8,C,10; InstrD lags by one; ValidD=0 only on the first cycle.
REQ-034 PCF=8, StallF=StallD=1 for 2 cycles -> PCF held at 8, InstrD/PCD held at instr@4/4; released -> instr@8 follows with no gap.
REQ-035 PCF=10, PCSrcE=1, PCTargetE=32'h40, FlushD=1 -> next edge PCF=40, InstrD=32'h13, ValidD=0; following edge InstrD=instr@40, PCD=40.
REQ-036 PCTargetE=32'h43 with PCSrcE=1 -> PCF=40; StallF=1 with PCSrcE=1 -> PCF=target; StallD=1 with FlushD=1 -> bubble loaded.
REQ-037 PCF=32'hFFFF_FFFC free-run -> PCPlus4D=0, next PCF=0.
REQ-038 rst=0 asserted during StallF=1 with PCSrcE=1 -> PCF=RESET_PC, InstrD=32'h13, ValidD=0 on that edge.
